// File: rtl/retire_monitor.sv
// retire_monitor: counts RUN cycles and retirements and gives a sticky pass/timeout/stall verdict.
// Optional 8-entry retired-PC history is enabled by defining RETIRE_HIST_EN.
module retire_monitor #(
    parameter int                ADDR_W      = 32,
    parameter int                CNT_W       = 32,
    parameter logic [ADDR_W-1:0] END_PC      = 32'h80000078,
    parameter int                TIMEOUT     = 100000,
    parameter int                STALL_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_en,
    input  logic              validW,
    input  logic [ADDR_W-1:0] pcW,
`ifdef RETIRE_HIST_EN
    input  logic [2:0]        hist_idx,
    output logic [ADDR_W-1:0] hist_pc,
`endif
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] last_pc
);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cycle_q, retired_q, cycle_d, retired_d;
    logic [SW-1:0]     stall_q;
    logic [ADDR_W-1:0] last_pc_q;
    logic              done_q, pass_q;
    logic [1:0]        fail_code_q;
    logic              active;

    assign active    = state_q == RUN && run_en;
    // Counters saturate at all-ones rather than wrapping
    assign cycle_d   = &cycle_q ? cycle_q : cycle_q + CNT_W'(1);
    assign retired_d = validW && !(&retired_q) ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cycle_q     <= '0;
            retired_q   <= '0;
            stall_q     <= '0;
            last_pc_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= 2'b00;
        end else if (state_q == IDLE) begin
            if (run_en) state_q <= RUN;
        end else if (active) begin
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
            stall_q   <= validW ? '0 : stall_q + SW'(1);
            if (validW) last_pc_q <= pcW;
            // Verdicts use pre-increment counters; END_PC beats timeout beats stall
            if (validW && pcW == END_PC) begin
                state_q <= PASS;
                done_q  <= 1'b1;
                pass_q  <= 1'b1;
            end else if (cycle_q == CNT_W'(TIMEOUT - 1)) begin
                state_q     <= FAIL;
                done_q      <= 1'b1;
                fail_code_q <= 2'b01;
            end else if (!validW && stall_q == SW'(STALL_LIMIT - 1)) begin
                state_q     <= FAIL;
                done_q      <= 1'b1;
                fail_code_q <= 2'b10;
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign retired_cnt = retired_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign last_pc     = last_pc_q;

`ifdef RETIRE_HIST_EN
    logic [ADDR_W-1:0] hist_q [8];
    logic [2:0]        wp_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q <= '0;
            for (int i = 0; i < 8; i++) hist_q[i] <= '0;
        end else if (active && validW) begin
            hist_q[wp_q] <= pcW;
            wp_q         <= wp_q + 3'd1;
        end
    end

    // Newest entry sits just behind the write pointer; 3-bit math wraps 7->0
    assign hist_pc = hist_q[wp_q - 3'd1 - hist_idx];
`endif
endmodule

// File: tb/tb_retire_monitor.sv
// tb_retire_monitor: directed and randomized checks of retire_monitor against a cycle-level reference model.
// Define RETIRE_HIST_EN to also check the retired-PC history.
module tb_retire_monitor;
    localparam int          TO  = 50;
    localparam int          SL  = 16;
    localparam logic [31:0] END = 32'h80000078;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run_en = 1'b0;
    logic        validW = 1'b0;
    logic [31:0] pcW = '0;
    logic [31:0] cycle_cnt, retired_cnt, last_pc;
    logic        done, pass;
    logic [1:0]  fail_code;
`ifdef RETIRE_HIST_EN
    logic [2:0]  hist_idx = '0;
    logic [31:0] hist_pc;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: 0 idle, 1 run, 2 pass, 3 fail
    int          m_st;
    int unsigned m_cyc, m_ret, m_stall;
    logic [31:0] m_last;
    logic        m_done, m_pass;
    logic [1:0]  m_code;
    logic [31:0] hq[$];

    retire_monitor #(.TIMEOUT(TO), .STALL_LIMIT(SL)) dut (
        .clk(clk), .reset(reset), .run_en(run_en), .validW(validW), .pcW(pcW),
`ifdef RETIRE_HIST_EN
        .hist_idx(hist_idx), .hist_pc(hist_pc),
`endif
        .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .done(done), .pass(pass),
        .fail_code(fail_code), .last_pc(last_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic rst, input logic r, input logic v, input logic [31:0] pc);
        if (!rst) begin
            m_st = 0; m_cyc = 0; m_ret = 0; m_stall = 0; m_last = 0;
            m_done = 0; m_pass = 0; m_code = 0;
            hq.delete();
        end else if (m_st == 0) begin
            if (r) m_st = 1;
        end else if (m_st == 1 && r) begin
            if (v && pc == END) begin
                m_st = 2; m_done = 1; m_pass = 1;
            end else if (m_cyc == TO - 1) begin
                m_st = 3; m_done = 1; m_code = 2'b01;
            end else if (!v && m_stall == SL - 1) begin
                m_st = 3; m_done = 1; m_code = 2'b10;
            end
            if (m_cyc != 32'hffffffff) m_cyc++;
            if (v) begin
                if (m_ret != 32'hffffffff) m_ret++;
                m_last = pc;
                m_stall = 0;
                hq.push_front(pc);
                if (hq.size() > 8) void'(hq.pop_back());
            end else m_stall++;
        end
    endtask

    task automatic compare_all();
        check("cycle_cnt", cycle_cnt, m_cyc);
        check("retired_cnt", retired_cnt, m_ret);
        check("done", done, m_done);
        check("pass", pass, m_pass);
        check("fail_code", fail_code, m_code);
        check("last_pc", last_pc, m_last);
`ifdef RETIRE_HIST_EN
        for (int i = 0; i < 8; i++) begin
            hist_idx = 3'(i);
            #1;
            check("hist_pc", hist_pc, i < hq.size() ? hq[i] : 32'h0);
        end
`endif
    endtask

    task automatic tick(input logic rst, input logic r, input logic v, input logic [31:0] pc);
        reset = rst; run_en = r; validW = v; pcW = pc;
        model(rst, r, v, pc);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] p;
        p = $urandom;
        return p == END ? p ^ 32'h4 : p;
    endfunction

    initial begin
        int n;
        // Reset, then retirements while idle are ignored
        repeat (3) tick(0, 0, 0, 0);
        check("rst_cycle", cycle_cnt, 0);
        check("rst_done", done, 0);
        repeat (5) tick(1, 0, 1, END);
        check("idle_retired", retired_cnt, 0);
        check("idle_last_pc", last_pc, 0);

        // Normal pass: 31 back-to-back retirements ending at END_PC
        tick(1, 1, 0, 0);
        for (int k = 0; k < 31; k++) tick(1, 1, 1, 32'h80000000 + 32'(4 * k));
        check("np_done", done, 1);
        check("np_pass", pass, 1);
        check("np_retired", retired_cnt, 31);
        check("np_cycle", cycle_cnt, 31);
        check("np_last_pc", last_pc, END);
        repeat (3) tick(1, 1, 1, rnd_pc());
        check("np_frozen", retired_cnt, 31);

        // Timeout: never reaches END_PC, gaps short enough to avoid stall
        tick(0, 0, 0, 0);
        tick(1, 1, 0, 0);
        for (int k = 0; k < TO; k++) tick(1, 1, (k % 4) != 3, rnd_pc());
        check("to_done", done, 1);
        check("to_pass", pass, 0);
        check("to_code", fail_code, 2'b01);
        check("to_cycle", cycle_cnt, TO);

        // Stall with a pause in the middle of the gap
        tick(0, 0, 0, 0);
        tick(1, 1, 0, 0);
        for (int k = 0; k < 10; k++) tick(1, 1, 1, rnd_pc());
        repeat (8) tick(1, 1, 0, rnd_pc());
        repeat (20) tick(1, 0, 1'($urandom), rnd_pc());
        check("st_pause_done", done, 0);
        check("st_pause_cycle", cycle_cnt, 18);
        n = 0;
        while (!done && n < 20) begin
            tick(1, 1, 0, rnd_pc());
            n++;
        end
        check("st_done", done, 1);
        check("st_remaining", n, 8);
        check("st_code", fail_code, 2'b10);
        check("st_cycle", cycle_cnt, 26);
        check("st_retired", retired_cnt, 10);

        // END_PC on the timeout cycle is a pass
        tick(0, 0, 0, 0);
        tick(1, 1, 0, 0);
        for (int k = 0; k < TO - 1; k++) tick(1, 1, 1, rnd_pc());
        tick(1, 1, 1, END);
        check("pr_pass", pass, 1);
        check("pr_code", fail_code, 2'b00);
        check("pr_cycle", cycle_cnt, TO);

        // Mid-run reset aborts, then rearm
        tick(0, 0, 0, 0);
        tick(1, 1, 0, 0);
        for (int k = 0; k < 5; k++) tick(1, 1, 1, rnd_pc());
        tick(0, 1, 1, rnd_pc());
        check("mr_cycle", cycle_cnt, 0);
        check("mr_retired", retired_cnt, 0);
        check("mr_last_pc", last_pc, 0);
        tick(1, 1, 0, 0);
        tick(1, 1, 1, END);
        check("mr_rearm_pass", pass, 1);
        check("mr_rearm_retired", retired_cnt, 1);

`ifdef RETIRE_HIST_EN
        tick(0, 0, 0, 0);
        tick(1, 1, 0, 0);
        for (int k = 0; k < 10; k++) tick(1, 1, 1, 32'hA0000000 + 32'(k));
        hist_idx = 3'd0; #1;
        check("hist_newest", hist_pc, 32'hA0000009);
        hist_idx = 3'd7; #1;
        check("hist_wrap", hist_pc, 32'hA0000002);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            hist_idx = 3'(i); #1;
            check("hist_rst", hist_pc, 0);
        end
`endif

        // Randomized episodes against the model
        for (int e = 0; e < 8; e++) begin
            tick(0, 0, 0, 0);
            for (int k = 0; k < 300; k++)
                tick(1, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
                     $urandom_range(0, 39) == 0 ? END : rnd_pc());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
